// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its soft-clear engine.
package regfile_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StDone  = 2'd2
  } clr_state_e;

  // Widest word merge_bytes handles; callers size-cast in and out.
  localparam int unsigned MaxXlen  = 256;
  localparam int unsigned MaxBytes = MaxXlen / 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < value) w++;
    return w;
  endfunction

  function automatic logic [MaxXlen-1:0] merge_bytes(input logic [MaxXlen-1:0]  old_word,
                                                     input logic [MaxXlen-1:0]  new_word,
                                                     input logic [MaxBytes-1:0] be);
    logic [MaxXlen-1:0] res;
    res = old_word;
    for (int k = 0; k < MaxBytes; k++) begin
      if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Soft-clear sequencer: walks clr_ptr over every register, flags writes dropped while busy.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_req,
  input  logic          we,
  output logic          busy,
  output logic          clr_done,
  output logic          wr_drop,
  output logic          clr_we,
  output logic          wr_allow,
  output logic [AW-1:0] clr_ptr
);

  localparam logic [AW-1:0] LastPtr = AW'(NREGS - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          wr_drop_q, wr_drop_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      clr_ptr_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_drop_d = wr_drop_q;
    clr_we    = 1'b0;
    wr_allow  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          // Starting a clear resets the sticky flag, but a colliding write still counts.
          state_d   = StClear;
          clr_ptr_d = '0;
          wr_drop_d = we;
        end else begin
          wr_allow = 1'b1;
        end
      end
      StClear: begin
        clr_we = 1'b1;
        if (we) wr_drop_d = 1'b1;
        if (clr_ptr_q == LastPtr) state_d = StDone;
        else clr_ptr_d = clr_ptr_q + AW'(1);
      end
      StDone: begin
        wr_allow = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q == StClear);
  assign clr_done = (state_q == StDone);
  assign wr_drop  = wr_drop_q;
  assign clr_ptr  = clr_ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with byte-enabled writes, bypass and soft clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned NDBG     = 4,
  localparam int unsigned AW      = clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [XLEN/8-1:0]     wbe,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_done,
  output logic                  wr_drop,
  output logic [NDBG*XLEN-1:0]  dbg
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            clr_we;
  logic            wr_allow;
  logic            wr_commit;
  logic [AW-1:0]   clr_ptr;

  function automatic logic [XLEN-1:0] merge_w(input logic [XLEN-1:0]   old_word,
                                              input logic [XLEN-1:0]   new_word,
                                              input logic [XLEN/8-1:0] be);
    return XLEN'(merge_bytes(MaxXlen'(old_word), MaxXlen'(new_word), MaxBytes'(be)));
  endfunction

  regfile_clr_fsm #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clr_fsm (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .we       (we),
    .busy     (busy),
    .clr_done (clr_done),
    .wr_drop  (wr_drop),
    .clr_we   (clr_we),
    .wr_allow (wr_allow),
    .clr_ptr  (clr_ptr)
  );

  // Writes to a hardwired-zero x0 never commit, so they also never bypass.
  assign wr_commit = we & wr_allow & ~((ZERO_REG != 0) & (waddr == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (clr_we) regs_d[clr_ptr] = '0;
    else if (wr_commit) regs_d[waddr] = merge_w(regs_q[waddr], wdata, wbe);
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit_zero;
    logic          hit_byp;
    assign ra       = raddr[p*AW +: AW];
    assign hit_zero = (ZERO_REG != 0) && (ra == '0);
    assign hit_byp  = (BYPASS != 0) && wr_commit && (ra == waddr);
    assign rdata[p*XLEN +: XLEN] = hit_zero ? '0 :
                                   hit_byp  ? merge_w(regs_q[ra], wdata, wbe) : regs_q[ra];
  end

  for (genvar i = 0; i < NDBG; i++) begin : g_dbg
    assign dbg[i*XLEN +: XLEN] = regs_q[i];
  end

endmodule
